// File: rtl/display_scanner.sv
// Multiplexed hex display scanner: time-shares one 7-segment bus across
// NUM_DIGITS active-low digit enables, with blanking gaps and tear-free frame updates.
module display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int DWELL       = 10000,
  parameter int DEAD_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    load,
  output logic                    busy,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL > DEAD_CYCLES) ? DWELL : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0]      DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] AN_BIT0    = NUM_DIGITS'(1);
  localparam logic [6:0]            SEG_OFF    = 7'b1111111;

  typedef enum logic [0:0] {
    ST_SHOW = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_dig_r;
  logic [NUM_DIGITS-1:0]   shadow_blank_r;
  logic [4*NUM_DIGITS-1:0] pend_dig_r;
  logic [NUM_DIGITS-1:0]   pend_blank_r;

  logic                    show_end_s;
  logic                    dead_end_s;
  logic                    commit_s;
  logic [IDX_W-1:0]        idx_next_s;
  logic [4*NUM_DIGITS-1:0] new_dig_s;
  logic [NUM_DIGITS-1:0]   new_blank_s;
  logic [3:0]              nib_s;
  logic                    blank_bit_s;
  logic [NUM_DIGITS-1:0]   an_show_s;
  logic [6:0]              seg_show_s;

  // Active-low 7-segment encoding, seg[0]=a .. seg[6]=g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Phase-end detection, commit decision and the digit pattern for the next SHOW slot.
  // The pattern looks through the commit so a freshly committed frame shows with no lag.
  always_comb begin
    show_end_s  = 1'b0;
    dead_end_s  = 1'b0;
    commit_s    = 1'b0;
    idx_next_s  = '0;
    new_dig_s   = shadow_dig_r;
    new_blank_s = shadow_blank_r;
    if ((state_r == ST_SHOW) && (cnt_r == DWELL_LAST)) begin
      show_end_s = 1'b1;
    end else begin
      show_end_s = 1'b0;
    end
    if ((state_r == ST_DEAD) && (cnt_r == DEAD_LAST)) begin
      dead_end_s = 1'b1;
    end else begin
      dead_end_s = 1'b0;
    end
    if (idx_r == IDX_LAST) begin
      idx_next_s = '0;
      commit_s   = dead_end_s;
    end else begin
      idx_next_s = idx_r + IDX_W'(1);
      commit_s   = 1'b0;
    end
    if (commit_s && load) begin
      new_dig_s   = digits;
      new_blank_s = blank_mask;
    end else if (commit_s && busy) begin
      new_dig_s   = pend_dig_r;
      new_blank_s = pend_blank_r;
    end else begin
      new_dig_s   = shadow_dig_r;
      new_blank_s = shadow_blank_r;
    end
  end

  // Decode of the selected digit for the upcoming SHOW slot.
  always_comb begin
    nib_s       = new_dig_s[{idx_next_s, 2'b00} +: 4];
    blank_bit_s = new_blank_s[idx_next_s];
    an_show_s   = ~(AN_BIT0 << idx_next_s);
    seg_show_s  = hex_to_seg(nib_s);
  end

  // Pending/shadow double buffer: shadow moves only on commit edges, so a frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_dig_r   <= '0;
      shadow_blank_r <= '0;
      pend_dig_r     <= '0;
      pend_blank_r   <= '0;
      busy           <= 1'b0;
    end else if (commit_s) begin
      shadow_dig_r   <= new_dig_s;
      shadow_blank_r <= new_blank_s;
      busy           <= 1'b0;
    end else if (load) begin
      pend_dig_r     <= digits;
      pend_blank_r   <= blank_mask;
      busy           <= 1'b1;
    end else begin
      busy           <= busy;
    end
  end

  // Scan FSM; seg/an/frame_done change on the same edge as the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_DEAD;
      cnt_r      <= '0;
      idx_r      <= IDX_LAST;
      an         <= AN_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      frame_done <= commit_s;
      case (state_r)
        ST_SHOW: begin
          if (show_end_s) begin
            state_r <= ST_DEAD;
            cnt_r   <= '0;
            an      <= AN_OFF;
            seg     <= SEG_OFF;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_DEAD: begin
          if (dead_end_s) begin
            state_r <= ST_SHOW;
            cnt_r   <= '0;
            idx_r   <= idx_next_s;
            if (blank_bit_s) begin
              an  <= AN_OFF;
              seg <= SEG_OFF;
            end else begin
              an  <= an_show_s;
              seg <= seg_show_s;
            end
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_DEAD;
          cnt_r   <= '0;
          an      <= AN_OFF;
          seg     <= SEG_OFF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with NUM_DIGITS=2, DWELL=4, DEAD_CYCLES=2.
module tb_display_scanner;

  logic       clk;
  logic       reset;
  logic [7:0] digits;
  logic [1:0] blank_mask;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int checks;
  int errors;

  logic [6:0] seg_tbl [16];

  display_scanner #(
    .NUM_DIGITS (2),
    .DWELL      (4),
    .DEAD_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .blank_mask(blank_mask),
    .load      (load),
    .busy      (busy),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] an_e, input logic [6:0] seg_e,
                         input logic fd_e, input logic busy_e);
    checks++;
    assert (an === an_e) else begin
      errors++;
      $error("FAIL %s.an: observed=%b expected=%b", tag, an, an_e);
    end
    checks++;
    assert (seg === seg_e) else begin
      errors++;
      $error("FAIL %s.seg: observed=%b expected=%b", tag, seg, seg_e);
    end
    checks++;
    assert (frame_done === fd_e) else begin
      errors++;
      $error("FAIL %s.frame_done: observed=%b expected=%b", tag, frame_done, fd_e);
    end
    checks++;
    assert (busy === busy_e) else begin
      errors++;
      $error("FAIL %s.busy: observed=%b expected=%b", tag, busy, busy_e);
    end
  endtask

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001;
    seg_tbl[2]  = 7'b0100100; seg_tbl[3]  = 7'b0110000;
    seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000;
    seg_tbl[8]  = 7'b0000000; seg_tbl[9]  = 7'b0010000;
    seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001;
    seg_tbl[14] = 7'b0000110; seg_tbl[15] = 7'b0001110;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    load = 1'b0;
    digits = 8'h00;
    blank_mask = 2'b00;

    // asynchronous reset, before any clock edge
    #2 reset = 1'b0;
    #1;
    chk_out("rst_async", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick(2);
    chk_out("rst_hold", 2'b11, 7'b1111111, 1'b0, 1'b0);

    // release, no load: 2 blank cycles then commit with digit 0 showing 0
    reset = 1'b1;
    tick();
    chk_out("e1_blank", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick();
    chk_out("e2_commit", 2'b10, 7'b1000000, 1'b1, 1'b0);
    tick();
    chk_out("e3_show0", 2'b10, 7'b1000000, 1'b0, 1'b0);
    tick(2);
    chk_out("e5_show0_last", 2'b10, 7'b1000000, 1'b0, 1'b0);
    tick();
    chk_out("e6_dead", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick(2);
    chk_out("e8_show1", 2'b01, 7'b1000000, 1'b0, 1'b0);
    tick(5);
    chk_out("e13_dead", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick();
    chk_out("e14_commit", 2'b10, 7'b1000000, 1'b1, 1'b0);

    // mid-frame load of A5: old values hold until the next commit
    tick();
    digits = 8'hA5;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_out("e16_pending", 2'b10, 7'b1000000, 1'b0, 1'b1);
    tick(4);
    chk_out("e20_old_d1", 2'b01, 7'b1000000, 1'b0, 1'b1);
    tick(6);
    chk_out("e26_a5_d0", 2'b10, 7'b0010010, 1'b1, 1'b0);
    tick(6);
    chk_out("e32_a5_d1", 2'b01, 7'b0001000, 1'b0, 1'b0);

    // decode sweep 0..F on digit 0, one value per frame
    digits = 8'h00;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick(5);
    for (int v = 0; v < 16; v++) begin
      chk_out($sformatf("sweep_%0h", v), 2'b10, seg_tbl[v], 1'b1, 1'b0);
      if (v < 15) begin
        digits = 8'(v + 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        tick(11);
      end
    end

    // blank digit 1, digit 0 shows C
    digits = 8'h3C;
    blank_mask = 2'b10;
    load = 1'b1;
    tick();
    load = 1'b0;
    blank_mask = 2'b00;
    tick(11);
    chk_out("blank_d0", 2'b10, 7'b1000110, 1'b1, 1'b0);
    tick(6);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("blank_d1_%0d", k), 2'b11, 7'b1111111, 1'b0, 1'b0);
      if (k < 3) tick();
    end

    // pending 22, then load 07 on the commit edge: 07 wins, 22 is discarded
    digits = 8'h22;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_out("pend_22", 2'b11, 7'b1111111, 1'b0, 1'b1);
    tick();
    digits = 8'h07;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_out("load_on_commit", 2'b10, 7'b1111000, 1'b1, 1'b0);
    tick();
    chk_out("load_on_commit_next", 2'b10, 7'b1111000, 1'b0, 1'b0);
    tick(11);
    chk_out("old_pend_dropped", 2'b10, 7'b1111000, 1'b1, 1'b0);

    // reset between edges mid-SHOW with a pending load
    digits = 8'h99;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_out("pend_99", 2'b10, 7'b1111000, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk_out("rst_mid", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick(2);
    reset = 1'b1;
    tick();
    chk_out("post_rst_blank", 2'b11, 7'b1111111, 1'b0, 1'b0);
    tick();
    chk_out("post_rst_commit", 2'b10, 7'b1000000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_DIGITS, 4, number of multiplexed hex digits (legal 1..8).
- DWELL, 10000, clk cycles each digit is driven (legal >= 1).
- DEAD_CYCLES, 100, all-off blanking cycles between digits (legal >= 1).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- digits, input, 4*NUM_DIGITS, hex nibbles; digit i is bits [4i+3:4i].
- blank_mask, input, NUM_DIGITS, bit i=1 blanks digit i.
- load, input, 1, request to capture digits and blank_mask.
- busy, output, 1, capture pending, not yet displayed.
- seg, output, 7, active-low segments, seg[0]=a .. seg[6]=g.
- an, output, NUM_DIGITS, active-low digit enables.
- frame_done, output, 1, one-cycle pulse at each frame commit.
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have two states: SHOW and DEAD, with a cycle counter cnt and digit index idx (0..NUM_DIGITS-1).
REQ-005 SHOW SHALL last exactly DWELL cycles, then go to DEAD with cnt=0.
REQ-006 DEAD SHALL last exactly DEAD_CYCLES cycles, then go to SHOW with idx=idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-007 The DEAD -> SHOW transition with idx==NUM_DIGITS-1 SHALL be the commit edge; NUM_DIGITS=1 makes every DEAD exit a commit.
REQ-008 seg, an and frame_done SHALL be registers updated on the same edge as the state change they reflect, with no extra latency.
REQ-009 In DEAD: an SHALL be all ones and seg SHALL be 7'b1111111.
REQ-010 In SHOW with shadow blank bit idx=0: an SHALL have only bit idx low, and seg SHALL equal decode(shadow nibble idx).
REQ-011 In SHOW with shadow blank bit idx=1: an SHALL be all ones and seg SHALL be 7'b1111111; timing SHALL be unchanged.
REQ-012 decode SHALL map hex digits to seg[6:0] as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-013 Full frame period SHALL be NUM_DIGITS*(DWELL+DEAD_CYCLES) cycles.
REQ-014 load=1 on a clk edge SHALL capture digits and blank_mask into a pending register and set busy=1 on that edge.
REQ-015 On the commit edge, if busy=1, the pending data SHALL copy into the shadow register and busy SHALL clear.
REQ-016 The shadow register SHALL change only on commit edges, so no tearing occurs within a frame.
REQ-017 load while busy=1 SHALL overwrite the pending data (latest wins).
REQ-018 load on the commit edge SHALL write digits and blank_mask straight into the shadow register; busy SHALL end 0 and any older pending data SHALL be discarded.
REQ-019 frame_done SHALL be 1 for exactly the cycle following each commit edge and 0 otherwise.
REQ-020 The counter width SHALL be $clog2(max(DWELL,DEAD_CYCLES)+1); the counter SHALL not overflow at any legal parameter value.

Reset
REQ-021 While reset=0, outputs SHALL take these values immediately, without waiting for a clock edge:
- an = all ones, seg = 7'b1111111
- frame_done = 0, busy = 0
REQ-022 While reset=0, internal state SHALL reset as follows:
- shadow and pending digits = 0, shadow and pending blank_mask = 0
- state = DEAD, cnt = 0, idx = NUM_DIGITS-1
REQ-023 After reset release, the first commit edge SHALL occur DEAD_CYCLES edges later; digit 0 SHALL then show 0 (seg=1000000).
REQ-024 Reset asserted mid-operation SHALL abort the frame and discard any pending load.

Verification (NUM_DIGITS=2, DWELL=4, DEAD_CYCLES=2)
REQ-025 The bench SHALL cover the following directed scenarios, each as stimulus -> required response:
- Release reset, no load -> 2 blank cycles; then frame_done pulse; then an=10 and seg=1000000 for 4 cycles; frame_done pulses every 12 cycles.
- load with digits=8'hA5 mid-frame -> busy=1 until the next commit; then digit 0 shows seg=0010010 and digit 1 shows seg=0001000; the old values hold until the commit.
- Sweep load over 0..F on digit 0, one per frame -> seg matches the REQ-012 table for every value.
- blank_mask=2'b10 -> digit-1 slot gives an=11 and seg=1111111 for 4 cycles; digit 0 is unaffected.
- load coincident with the commit edge -> the new value shows in that frame's digit-0 slot; busy never rises.
- Assert reset mid-SHOW between edges -> an=11, seg=1111111, busy=0 immediately; the pending load is lost after release.
